// File: rtl/care_action_arbiter_pkg.sv
// Shared constants, state encoding and round-robin helper for the care action arbiter.
package care_pkg;

    localparam int ACT_W = 2;
    localparam int N_ACT = 4;

    localparam logic [ACT_W-1:0] ACT_SALUD     = 2'd0;
    localparam logic [ACT_W-1:0] ACT_ENERGIA   = 2'd1;
    localparam logic [ACT_W-1:0] ACT_HAMBRE    = 2'd2;
    localparam logic [ACT_W-1:0] ACT_DIVERSION = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // First set request bit searching upward from last+1, wrapping mod N_ACT.
    function automatic logic [ACT_W-1:0] rr_pick(input logic [N_ACT-1:0] req,
                                                 input logic [ACT_W-1:0] last);
        logic [ACT_W-1:0] idx;
        logic             found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 1; i <= N_ACT; i++) begin
            idx = last + ACT_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/care_action_arbiter_if.sv
// Valid/ready action port between the care arbiter (master) and the pet FSM (slave).
interface care_action_arbiter_if;
    import care_pkg::*;

    // act_valid rises only with a stable act_code and stays high, code unchanged,
    // until the cycle in which act_ready is also high; that cycle is the transfer.
    logic             act_valid;
    logic             act_ready;
    logic [ACT_W-1:0] act_code;

    modport master (output act_valid, output act_code, input act_ready);
    modport slave  (input act_valid, input act_code, output act_ready);
endinterface

// File: rtl/care_action_arbiter_edge_latch.sv
// Per-button rising-edge detector with a sticky pending bit and a dropped-press pulse.
module care_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic pending,
    output logic drop
);

    logic prev_q, prev_d;
    logic pend_q, pend_d;
    logic rise;

    always_comb begin
        rise   = btn & ~prev_q;
        prev_d = btn;
        pend_d = pend_q;
        // A new press in the same cycle as the grant re-arms the request.
        if (clr)  pend_d = 1'b0;
        if (rise) pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= btn;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
    assign drop    = rise & pend_q;

endmodule

// File: rtl/care_action_arbiter.sv
// Round-robin arbiter of the four care buttons onto the pet FSM action port, with cooldown
// and a held-button test mode. Define CARE_ARB_DROP_CNT_EN to build the dropped-press counter.
module care_action_arbiter
    import care_pkg::*;
#(
    parameter int COOLDOWN  = 25,
    parameter int HOLD_TEST = 250
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_salud,
    input  logic                         btn_energia,
    input  logic                         btn_hambre,
    input  logic                         btn_diversion,
    input  logic                         btn_test,
    care_action_arbiter_if.master        act,
    output logic [N_ACT-1:0]             pending,
    output logic                         busy,
    output logic                         test_mode,
    output logic [7:0]                   drop_cnt,
    output state_t                       state_dbg
);

    localparam int CD_W   = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int HOLD_W = $clog2(HOLD_TEST + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TEST);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_TEST - 1);

    logic [N_ACT-1:0] btn_vec, clr_vec, drop_vec;

    state_t            state_q, state_d;
    logic              act_valid_q, act_valid_d;
    logic [ACT_W-1:0]  act_code_q, act_code_d;
    logic [ACT_W-1:0]  last_q, last_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              test_mode_q, test_mode_d;
    logic              hs;

    assign btn_vec = {btn_diversion, btn_hambre, btn_energia, btn_salud};
    assign hs      = act_valid_q & act.act_ready;

    for (genvar i = 0; i < N_ACT; i++) begin : g_latch
        assign clr_vec[i] = hs & (act_code_q == ACT_W'(i));
        care_edge_latch u_latch (
            .clk     (clk),
            .reset   (reset),
            .btn     (btn_vec[i]),
            .clr     (clr_vec[i]),
            .pending (pending[i]),
            .drop    (drop_vec[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        act_valid_d = act_valid_q;
        act_code_d  = act_code_q;
        last_d      = last_q;
        cd_d        = cd_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    act_code_d  = rr_pick(pending, last_q);
                    act_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (hs) begin
                    act_valid_d = 1'b0;
                    last_d      = act_code_q;
                    if (COOLDOWN > 0 && !test_mode_q) begin
                        state_d = ST_COOLDOWN;
                        cd_d    = CD_W'(COOLDOWN - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COOLDOWN: begin
                // Test mode cuts any running cooldown short.
                if (test_mode_q || cd_q == '0) state_d = ST_IDLE;
                else                           cd_d    = cd_q - CD_W'(1);
            end
            default: begin
                state_d     = ST_IDLE;
                act_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        test_mode_d = test_mode_q;
        if (!btn_test) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_PRE) test_mode_d = ~test_mode_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            act_valid_q <= 1'b0;
            act_code_q  <= '0;
            last_q      <= ACT_DIVERSION;
            cd_q        <= '0;
            hold_q      <= '0;
            test_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_valid_q <= act_valid_d;
            act_code_q  <= act_code_d;
            last_q      <= last_d;
            cd_q        <= cd_d;
            hold_q      <= hold_d;
            test_mode_q <= test_mode_d;
        end
    end

`ifdef CARE_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q} + 9'(drop_vec[0]) + 9'(drop_vec[1])
                 + 9'(drop_vec[2]) + 9'(drop_vec[3]);
        drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop_vec;
    assign drop_cnt    = '0;
`endif

    assign act.act_valid = act_valid_q;
    assign act.act_code  = act_code_q;
    assign busy          = (state_q != ST_IDLE);
    assign test_mode     = test_mode_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_care_action_arbiter.sv
// Directed bench for care_action_arbiter with hand-computed expectations.
module tb_care_action_arbiter;
    import care_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_test;
    logic [3:0] pending;
    logic       busy, test_mode;
    logic [7:0] drop_cnt;
    state_t     state_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         t_q[$];

    care_action_arbiter_if act_if ();

    care_action_arbiter #(.COOLDOWN(25), .HOLD_TEST(250)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_salud     (btn_salud),
        .btn_energia   (btn_energia),
        .btn_hambre    (btn_hambre),
        .btn_diversion (btn_diversion),
        .btn_test      (btn_test),
        .act           (act_if),
        .pending       (pending),
        .busy          (busy),
        .test_mode     (test_mode),
        .drop_cnt      (drop_cnt),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // observe 1 time unit after the active edge; inputs changed here are sampled next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    logic [7:0] exp_drop;
    int         busy_cycles, valid_cycles, toggles, guard;
    logic       prev_tm;
    logic [7:0] got_code;
    int         got_t, prev_t;

    initial begin
        reset = 1'b1;
        btn_salud = 0; btn_energia = 0; btn_diversion = 0; btn_test = 0;
        btn_hambre = 1'b1;
        act_if.act_ready = 1'b0;

        // reset with hambre held: no edge afterwards
        ticks(2);
        reset = 1'b0;
        tick();
        check("rst_pending",   pending, 4'b0000);
        check("rst_valid",     act_if.act_valid, 1'b0);
        check("rst_code",      act_if.act_code, 2'd0);
        check("rst_busy",      busy, 1'b0);
        check("rst_test_mode", test_mode, 1'b0);
        check("rst_drop",      drop_cnt, 8'd0);
        check("rst_state",     state_dbg, ST_IDLE);
        ticks(4);
        check("held_no_valid", act_if.act_valid, 1'b0);
        check("held_no_pend",  pending, 4'b0000);
        btn_hambre = 1'b0;
        tick();

        // single energia press with cooldown 25
        btn_energia = 1'b1;
        act_if.act_ready = 1'b1;
        tick();
        check("en_pending", pending, 4'b0010);
        check("en_valid_n1", act_if.act_valid, 1'b0);
        btn_energia = 1'b0;
        tick();
        check("en_valid_n2", act_if.act_valid, 1'b1);
        check("en_code", act_if.act_code, ACT_ENERGIA);
        busy_cycles = 0;
        valid_cycles = 0;
        guard = 0;
        while (busy && guard < 100) begin
            busy_cycles++;
            if (act_if.act_valid) valid_cycles++;
            guard++;
            tick();
        end
        check("en_busy_cycles", busy_cycles, 26);
        check("en_valid_cycles", valid_cycles, 1);
        check("en_pend_clear", pending, 4'b0000);

        // test mode: hold 600, expect a single toggle at cycle 250
        do_reset();
        tick();
        btn_test = 1'b1;
        prev_tm = test_mode;
        toggles = 0;
        for (int k = 1; k <= 600; k++) begin
            tick();
            if (test_mode !== prev_tm) toggles++;
            prev_tm = test_mode;
            if (k == 249) check("tm_249", test_mode, 1'b0);
            if (k == 250) check("tm_250", test_mode, 1'b1);
        end
        check("tm_toggles", toggles, 1);
        btn_test = 1'b0;
        tick();
        check("tm_after_release", test_mode, 1'b1);

        // four simultaneous presses in test mode: grants 0,1,2,3 with no cooldown gap
        btn_salud = 1; btn_energia = 1; btn_hambre = 1; btn_diversion = 1;
        act_if.act_ready = 1'b1;
        tick();
        check("all_pending", pending, 4'b1111);
        btn_salud = 0; btn_energia = 0; btn_hambre = 0; btn_diversion = 0;
        exp_q = {8'd0, 8'd1, 8'd2, 8'd3};
        got_q.delete();
        t_q.delete();
        for (int t = 0; t < 14; t++) begin
            if (act_if.act_valid) begin
                got_q.push_back(8'(act_if.act_code));
                t_q.push_back(t);
            end
            tick();
        end
        check("rr_count", got_q.size(), 4);
        prev_t = -1;
        while (exp_q.size() > 0) begin
            if (got_q.size() > 0) begin
                got_code = got_q.pop_front();
                got_t    = t_q.pop_front();
            end else begin
                got_code = 8'hFF;
                got_t    = -100;
            end
            check("rr_code", got_code, exp_q.pop_front());
            if (prev_t >= 0) check("rr_gap", got_t - prev_t, 2);
            prev_t = got_t;
        end
        check("rr_pend_end", pending, 4'b0000);
        check("rr_idle_end", busy, 1'b0);

        // hold again for 250 cycles: back to normal mode
        btn_test = 1'b1;
        ticks(249);
        check("tm2_249", test_mode, 1'b1);
        tick();
        check("tm2_250", test_mode, 1'b0);
        btn_test = 1'b0;
        tick();

        // stalled offer of hambre with two extra presses
        do_reset();
        act_if.act_ready = 1'b0;
        btn_hambre = 1'b1;
        tick();
        btn_hambre = 1'b0;
        tick();
        check("st_valid", act_if.act_valid, 1'b1);
        check("st_code", act_if.act_code, ACT_HAMBRE);
        for (int p = 0; p < 2; p++) begin
            btn_hambre = 1'b1;
            tick();
            btn_hambre = 1'b0;
            tick();
        end
`ifdef CARE_ARB_DROP_CNT_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
`endif
        check("st_drop", drop_cnt, exp_drop);
        check("st_valid_hold", act_if.act_valid, 1'b1);
        check("st_code_hold", act_if.act_code, ACT_HAMBRE);
        check("st_pending", pending, 4'b0100);

        // handshake and a new hambre edge in the same cycle: edge wins
        act_if.act_ready = 1'b1;
        btn_hambre = 1'b1;
        tick();
        btn_hambre = 1'b0;
        act_if.act_ready = 1'b0;
        check("ew_pending", pending, 4'b0100);
        check("ew_valid", act_if.act_valid, 1'b0);
        check("ew_cooldown", state_dbg, ST_COOLDOWN);

        // reset during OFFER
        guard = 0;
        while (!act_if.act_valid && guard < 60) begin
            guard++;
            tick();
        end
        check("ro_offer_seen", act_if.act_valid, 1'b1);
        btn_salud = 1'b1;
        tick();
        btn_salud = 1'b0;
        check("ro_pend_before", pending, 4'b0101);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ro_valid", act_if.act_valid, 1'b0);
        check("ro_pending", pending, 4'b0000);
        check("ro_state", state_dbg, ST_IDLE);
        tick();
        check("ro_stay_idle", act_if.act_valid, 1'b0);
        btn_diversion = 1'b1;
        act_if.act_ready = 1'b1;
        tick();
        btn_diversion = 1'b0;
        tick();
        check("ro_restart_valid", act_if.act_valid, 1'b1);
        check("ro_restart_code", act_if.act_code, ACT_DIVERSION);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
